// File: rtl/mem_writer_18bit_pkg.sv
// Shared definitions for the decompressor memory address counters (read and write side).
package mem_writer_18bit_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_writer_18bit_addr_gen.sv
// Loadable wrapping address counter with an equality-to-limit flag.
module addr_gen_18bit
  import mem_writer_18bit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_lim,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              at_lim
);

  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] lim_r;

  // Address/limit registers; the increment wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (clear) begin
      addr_r <= {ADDR_W{1'b0}};
      lim_r  <= {ADDR_W{1'b0}};
    end else if (load) begin
      addr_r <= load_addr;
      lim_r  <= load_lim;
    end else if (inc) begin
      addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  assign addr   = addr_r;
  assign at_lim = (addr_r == lim_r);

endmodule

// File: rtl/mem_writer_18bit.sv
// Write-side address generator and byte sink feeding the decompressor output RAM.
module mem_writer_18bit
  import mem_writer_18bit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] limit,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              w_en,
  output logic              write_done,
  output logic [ADDR_W:0]   write_count
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic              in_ready_s;
  logic              hs_s;
  logic              start_ok_s;
  logic [ADDR_W-1:0] addr_s;
  logic              at_lim_s;

  logic [ADDR_W-1:0] w_addr_r;
  logic [DATA_W-1:0] w_data_r;
  logic              w_en_r;
  logic              write_done_r;
  logic [ADDR_W:0]   write_count_r;

  assign hs_s       = in_valid & in_ready_s;
  // start is only honoured outside a run; in RUN it is ignored.
  assign start_ok_s = start & (state_r != RUN);

  addr_gen_18bit #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .clear     (clear),
    .load      (start_ok_s),
    .load_addr (start_addr),
    .load_lim  (limit),
    .inc       (hs_s & ~at_lim_s),
    .addr      (addr_s),
    .at_lim    (at_lim_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (hs_s && at_lim_s) state_nxt_s = DONE;
        else                  state_nxt_s = RUN;
      end
      DONE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: ready only while a run is active.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      RUN:     in_ready_s = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
  end

  // RAM write port, done flag and byte counter.
  always_ff @(posedge clk) begin
    if (clear) begin
      w_en_r        <= 1'b0;
      w_addr_r      <= {ADDR_W{1'b0}};
      w_data_r      <= {DATA_W{1'b0}};
      write_done_r  <= 1'b0;
      write_count_r <= {(ADDR_W+1){1'b0}};
    end else begin
      w_en_r <= hs_s;
      if (hs_s) begin
        w_addr_r      <= addr_s;
        w_data_r      <= in_data;
        write_count_r <= write_count_r + {{ADDR_W{1'b0}}, 1'b1};
        if (at_lim_s) write_done_r <= 1'b1;
      end else if (start_ok_s) begin
        write_count_r <= {(ADDR_W+1){1'b0}};
        write_done_r  <= 1'b0;
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign w_en        = w_en_r;
  assign w_addr      = w_addr_r;
  assign w_data      = w_data_r;
  assign write_done  = write_done_r;
  assign write_count = write_count_r;

endmodule

// File: tb/tb_mem_writer_18bit.sv
// Directed bench for mem_writer_18bit: per-cycle comparison against a run-length model
// plus literal checks of the written address/data sequences.
module tb_mem_writer_18bit;

  logic        clk;
  logic        clear;
  logic        start;
  logic [17:0] start_addr;
  logic [17:0] limit;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] w_addr;
  logic [7:0]  w_data;
  logic        w_en;
  logic        write_done;
  logic [18:0] write_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  // model state
  bit          m_run   = 1'b0;
  int          m_next  = 0;
  int          m_rem   = 0;
  bit          e_wen   = 1'b0;
  logic [17:0] e_waddr = 18'd0;
  logic [7:0]  e_wdata = 8'd0;
  bit          e_done  = 1'b0;
  logic [18:0] e_count = 19'd0;

  logic [17:0] ga[$];
  logic [7:0]  gd[$];
  logic [17:0] ea[$];
  logic [7:0]  ed[$];

  logic [47:0] dut_v;
  logic [47:0] exp_v;
  assign dut_v = {in_ready, w_en, w_addr, w_data, write_done, write_count};
  assign exp_v = {m_run, e_wen, e_waddr, e_wdata, e_done, e_count};

  mem_writer_18bit dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .start_addr  (start_addr),
    .limit       (limit),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .w_en        (w_en),
    .write_done  (write_done),
    .write_count (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a run is a count of remaining bytes starting at start_addr, wrapping mod 2^18.
  always @(posedge clk) begin
    if (clear) begin
      m_run <= 1'b0; e_wen <= 1'b0; e_waddr <= 18'd0; e_wdata <= 8'd0;
      e_done <= 1'b0; e_count <= 19'd0;
    end else begin
      e_wen <= 1'b0;
      if (m_run && in_valid) begin
        e_wen   <= 1'b1;
        e_waddr <= m_next[17:0];
        e_wdata <= in_data;
        e_count <= e_count + 19'd1;
        m_rem   <= m_rem - 1;
        m_next  <= (m_next + 1) & 32'h3FFFF;
        if (m_rem == 1) begin
          m_run  <= 1'b0;
          e_done <= 1'b1;
        end
      end else if (!m_run && start) begin
        m_run   <= 1'b1;
        m_next  <= int'(start_addr);
        m_rem   <= ((int'(limit) - int'(start_addr)) & 32'h3FFFF) + 1;
        e_count <= 19'd0;
        e_done  <= 1'b0;
      end
    end
  end

  // Per-cycle compare and write collector.
  always @(negedge clk) begin
    if (chk_en) chk("cycle", {16'd0, dut_v}, {16'd0, exp_v});
    if (w_en === 1'b1) begin
      ga.push_back(w_addr);
      gd.push_back(w_data);
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [17:0] sa, input logic [17:0] lim);
    ga.delete(); gd.delete(); ea.delete(); ed.delete();
    start = 1'b1; start_addr = sa; limit = lim; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_writes(input string name);
    #1;
    chk({name, "_n"}, 64'(ga.size()), 64'(ea.size()));
    for (int i = 0; i < ga.size() && i < ea.size(); i++) begin
      chk($sformatf("%s_a%0d", name, i), 64'(ga[i]), 64'(ea[i]));
      chk($sformatf("%s_d%0d", name, i), 64'(gd[i]), 64'(ed[i]));
    end
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; start_addr = 18'd0; limit = 18'd0;
    in_data = 8'd0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", {16'd0, dut_v}, 64'd0);
    chk_en = 1'b1;
    clear  = 1'b0;

    // Basic 4-byte run with valid held beyond the limit
    do_start(18'h00010, 18'h00013);
    for (int i = 0; i < 6; i++) drive(1'b1, 8'hA0 + 8'(i));
    idle(2);
    ea = '{18'h10, 18'h11, 18'h12, 18'h13}; ed = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    chk_writes("run4");
    chk("run4_count", 64'(write_count), 64'd4);
    chk("run4_done", 64'(write_done), 64'd1);
    chk("run4_ready", 64'(in_ready), 64'd0);

    // Single byte, start == limit
    do_start(18'h2AAAA, 18'h2AAAA);
    drive(1'b1, 8'h5C);
    idle(3);
    ea = '{18'h2AAAA}; ed = '{8'h5C};
    chk_writes("one");
    chk("one_count", 64'(write_count), 64'd1);
    chk("one_done", 64'(write_done), 64'd1);

    // Wrap through zero
    do_start(18'h3FFFE, 18'h00001);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h01 + 8'(i));
    idle(2);
    ea = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001}; ed = '{8'h01, 8'h02, 8'h03, 8'h04};
    chk_writes("wrap");
    chk("wrap_count", 64'(write_count), 64'd4);

    // Gapped valid 1,0,0,1,1
    do_start(18'h00100, 18'h00102);
    drive(1'b1, 8'h11); drive(1'b0, 8'h22); drive(1'b0, 8'h33);
    drive(1'b1, 8'h44); drive(1'b1, 8'h55);
    idle(2);
    ea = '{18'h100, 18'h101, 18'h102}; ed = '{8'h11, 8'h44, 8'h55};
    chk_writes("gap");
    chk("gap_done", 64'(write_done), 64'd1);

    // Clear mid-run, with a byte offered on the clear edge
    do_start(18'h00300, 18'h0030F);
    drive(1'b1, 8'h01); drive(1'b1, 8'h02);
    clear = 1'b1;
    drive(1'b1, 8'h03);
    clear = 1'b0;
    chk("clear_outs", {16'd0, dut_v}, 64'd0);
    idle(1);
    ea = '{18'h300, 18'h301}; ed = '{8'h01, 8'h02};
    chk_writes("pre_clr");
    do_start(18'h00200, 18'h00201);
    drive(1'b1, 8'hC1); drive(1'b1, 8'hC2);
    idle(2);
    ea = '{18'h200, 18'h201}; ed = '{8'hC1, 8'hC2};
    chk_writes("post_clr");

    // start ignored in RUN, honoured in DONE
    do_start(18'h00400, 18'h00403);
    drive(1'b1, 8'h40);
    start = 1'b1; start_addr = 18'h00999; limit = 18'h00999;
    drive(1'b1, 8'h41);
    start = 1'b0;
    drive(1'b1, 8'h42); drive(1'b1, 8'h43);
    idle(2);
    ea = '{18'h400, 18'h401, 18'h402, 18'h403}; ed = '{8'h40, 8'h41, 8'h42, 8'h43};
    chk_writes("ign");
    chk("ign_done", 64'(write_done), 64'd1);
    do_start(18'h00500, 18'h00500);
    chk("restart_done", 64'(write_done), 64'd0);
    chk("restart_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 8'h50);
    idle(2);
    ea = '{18'h500}; ed = '{8'h50};
    chk_writes("restart");
    chk("restart_count", 64'(write_count), 64'd1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
